// File: rtl/sram_responder.sv
// Behavioural SRAM slave with byte-lane writes and fixed-latency registered reads that can be aborted.
// Define SRAM_RESPONDER_ERR_CNT_EN to build the saturating counter of writes ignored during a read.
module sram_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sram_ce_n,
   input  logic                  sram_we_n,
   input  logic                  sram_oe_n,
   input  logic                  sram_ub_n,
   input  logic                  sram_lb_n,
   input  logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [DATA_WIDTH-1:0] sram_wr_data,
   output logic [DATA_WIDTH-1:0] sram_rd_data,
   output logic                  sram_rd_valid,
   output logic [7:0]            err_cnt
);

   localparam int LANE = DATA_WIDTH / 2;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RD_DONE = 2'd2;

   localparam logic [3:0] WAIT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ub_n;
   logic                  rd_lb_n;

   logic                  wr_req;
   logic                  rd_req;
   logic                  accept;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_masked;

   assign wr_req  = !sram_ce_n && !sram_we_n;
   assign rd_req  = !sram_ce_n && sram_we_n && !sram_oe_n;
   assign accept  = (state != RD_WAIT);
   assign rd_word = mem[rd_addr];

   assign rd_masked = {rd_ub_n ? {(DATA_WIDTH - LANE){1'b0}} : rd_word[DATA_WIDTH-1:LANE],
                       rd_lb_n ? {LANE{1'b0}}                : rd_word[LANE-1:0]};

   // NOTE: the storage array has no reset branch; only control state is cleared, so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (accept && wr_req) begin
         if (!sram_ub_n) mem[sram_addr][DATA_WIDTH-1:LANE] <= sram_wr_data[DATA_WIDTH-1:LANE];
         if (!sram_lb_n) mem[sram_addr][LANE-1:0]          <= sram_wr_data[LANE-1:0];
      end
   end

   // RD_DONE is the array-access cycle; its result is registered as the FSM leaves it,
   // so valid rises RD_LATENCY edges after the request edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         rd_addr       <= '0;
         rd_ub_n       <= 1'b1;
         rd_lb_n       <= 1'b1;
         sram_rd_data  <= '0;
         sram_rd_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking updates throughout, so every branch sees the pre-edge state.
         sram_rd_valid <= 1'b0;
         if (state == RD_DONE) begin
            sram_rd_data  <= rd_masked;
            sram_rd_valid <= 1'b1;
         end

         case (state)
            RD_WAIT: begin
               if (sram_ce_n)       state <= IDLE;
               else if (cnt == 4'd0) state <= RD_DONE;
               else                  cnt   <= cnt - 4'd1;
            end
            default: begin
               if (rd_req && !wr_req) begin
                  rd_addr <= sram_addr;
                  rd_ub_n <= sram_ub_n;
                  rd_lb_n <= sram_lb_n;
                  if (RD_LATENCY == 1) begin
                     state <= RD_DONE;
                  end else begin
                     state <= RD_WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef SRAM_RESPONDER_ERR_CNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 8'd0;
      else if ((state == RD_WAIT) && wr_req && (err_q != 8'hFF))
         err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: two instances (latency 2 and 4) share stimulus;
// a queue-based reference model predicts reads, a negedge monitor pops and compares.
module tb_sram_responder;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce_n  = 1'b1;
   logic        we_n  = 1'b1;
   logic        oe_n  = 1'b1;
   logic        ub_n  = 1'b0;
   logic        lb_n  = 1'b0;
   logic [9:0]  addr  = '0;
   logic [15:0] wd    = '0;

   logic [15:0] rd_data2, rd_data4;
   logic        rd_valid2, rd_valid4;
   logic [7:0]  err2, err4;

   int checks = 0;
   int errors = 0;

`ifdef SRAM_RESPONDER_ERR_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   // Reference model state, index 0 = latency-2 instance, 1 = latency-4 instance.
   logic [15:0] mmem [2][1024];
   bit          pend [2];
   int          pend_edge [2];
   logic [9:0]  paddr [2];
   logic        pub [2];
   logic        plb [2];
   int          merr [2];
   logic [15:0] last [2];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   int          cyc = 0;

   always #5 clk = ~clk;

   sram_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RD_LATENCY(2)) dut_l2 (
      .clk(clk), .rst_n(rst_n), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
      .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_addr(addr), .sram_wr_data(wd),
      .sram_rd_data(rd_data2), .sram_rd_valid(rd_valid2), .err_cnt(err2)
   );

   sram_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RD_LATENCY(4)) dut_l4 (
      .clk(clk), .rst_n(rst_n), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
      .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_addr(addr), .sram_wr_data(wd),
      .sram_rd_data(rd_data4), .sram_rd_valid(rd_valid4), .err_cnt(err4)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lanes(input logic [15:0] v, input logic ub, input logic lb);
      return {ub ? 8'h00 : v[15:8], lb ? 8'h00 : v[7:0]};
   endfunction

   // One rising edge of the behavioural model: a read accepted at edge k is busy on edges
   // k+1 .. k+lat-1 and yields lanes(mem) at edge k+lat, before that edge's own write.
   task automatic model_step(input int d, input int lat);
      bit wr, rd;
      wr = !ce_n && !we_n;
      rd = !ce_n && we_n && !oe_n;
      if (pend[d] && cyc < pend_edge[d]) begin
         if (ce_n) pend[d] = 1'b0;
         else if (wr && CNT_ON && merr[d] < 255) merr[d]++;
      end else begin
         if (pend[d]) begin
            if (d == 0) q0.push_back(lanes(mmem[d][paddr[d]], pub[d], plb[d]));
            else        q1.push_back(lanes(mmem[d][paddr[d]], pub[d], plb[d]));
            pend[d] = 1'b0;
         end
         if (wr) begin
            if (!ub_n) mmem[d][addr][15:8] = wd[15:8];
            if (!lb_n) mmem[d][addr][7:0]  = wd[7:0];
         end else if (rd) begin
            pend[d]      = 1'b1;
            pend_edge[d] = cyc + lat;
            paddr[d]     = addr;
            pub[d]       = ub_n;
            plb[d]       = lb_n;
         end
      end
   endtask

   task automatic cycle(input logic ce, input logic we, input logic oe, input logic ub,
                        input logic lb, input logic [9:0] a, input logic [15:0] d);
      @(negedge clk); #1;
      ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; addr = a; wd = d;
      model_step(0, 2);
      model_step(1, 4);
      cyc++;
   endtask

   task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic ub, input logic lb);
      cycle(1'b0, 1'b0, 1'b1, ub, lb, a, d);
   endtask

   task automatic rd(input logic [9:0] a, input logic ub, input logic lb);
      cycle(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0);
   endtask

   task automatic nop();
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
   endtask

   // Issues a read and checks the exact latency-2 and latency-4 valid timing and data.
   task automatic read_check(input string tag, input logic [9:0] a, input logic ub,
                             input logic lb, input logic [15:0] exp);
      rd(a, ub, lb);
      for (int i = 1; i <= 5; i++) begin
         nop();
         if (i == 2) check({tag, "_l2_early"}, {15'b0, rd_valid2}, 16'h0);
         if (i == 3) begin
            check({tag, "_l2_valid"}, {15'b0, rd_valid2}, 16'h1);
            check({tag, "_l2_data"}, rd_data2, exp);
         end
         if (i == 4) check({tag, "_l4_early"}, {15'b0, rd_valid4}, 16'h0);
         if (i == 5) begin
            check({tag, "_l4_valid"}, {15'b0, rd_valid4}, 16'h1);
            check({tag, "_l4_data"}, rd_data4, exp);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         pend[d] = 1'b0;
         merr[d] = 0;
         last[d] = 16'h0;
      end
      q0.delete();
      q1.delete();
      #1;
      check("rst_valid_l2", {15'b0, rd_valid2}, 16'h0);
      check("rst_valid_l4", {15'b0, rd_valid4}, 16'h0);
      check("rst_data_l2", rd_data2, 16'h0);
      check("rst_data_l4", rd_data4, 16'h0);
      check("rst_err_l2", {8'h0, err2}, 16'h0);
      check("rst_err_l4", {8'h0, err4}, 16'h0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic mon(input int d, input logic v, input logic [15:0] data, input logic [7:0] e);
      logic [15:0] x;
      bit empty;
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (v) begin
         if (empty) begin
            check($sformatf("l%0d_rd_valid_spurious", 2 + 2 * d), {15'b0, v}, 16'h0);
         end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            check($sformatf("l%0d_rd_data", 2 + 2 * d), data, x);
            last[d] = x;
         end
      end else begin
         check($sformatf("l%0d_rd_data_hold", 2 + 2 * d), data, last[d]);
      end
      check($sformatf("l%0d_err_cnt", 2 + 2 * d), {8'h0, e}, merr[d][15:0]);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         pend[d] = 1'b0;
         merr[d] = 0;
         last[d] = 16'h0;
      end
      forever begin
         @(negedge clk);
         mon(0, rd_valid2, rd_data2, err2);
         mon(1, rd_valid4, rd_data4, err4);
      end
   end

   initial begin
      int          k;
      logic [9:0]  a;
      logic [15:0] v;
      logic [1:0]  ln;

      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Fill the whole array so no read ever returns uninitialised storage.
      for (int i = 0; i < 1024; i++) wr(10'(i), 16'($urandom), 1'b0, 1'b0);

      wr(10'h010, 16'hA55A, 1'b0, 1'b0);
      read_check("basic", 10'h010, 1'b0, 1'b0, 16'hA55A);

      wr(10'h020, 16'hFFFF, 1'b0, 1'b0);
      wr(10'h020, 16'h1234, 1'b1, 1'b0);
      read_check("lane_both", 10'h020, 1'b0, 1'b0, 16'hFF34);
      read_check("lane_upper", 10'h020, 1'b0, 1'b1, 16'hFF00);
      read_check("lane_none", 10'h020, 1'b1, 1'b1, 16'h0000);

      // Abort: chip enable drops while the latency-4 read is still waiting.
      rd(10'h010, 1'b0, 1'b0);
      nop();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         nop();
         check("abort_no_valid_l4", {15'b0, rd_valid4}, 16'h0);
      end
      wr(10'h030, 16'h5555, 1'b0, 1'b0);
      read_check("after_abort", 10'h030, 1'b0, 1'b0, 16'h5555);

      // A write during the wait is dropped and counted.
      rd(10'h010, 1'b0, 1'b0);
      wr(10'h010, 16'hBEEF, 1'b0, 1'b0);
      repeat (5) nop();
      read_check("ignored_wr", 10'h010, 1'b0, 1'b0, 16'hA55A);
      check("ignored_err_l2", {8'h0, err2}, CNT_ON ? 16'd1 : 16'd0);
      check("ignored_err_l4", {8'h0, err4}, CNT_ON ? 16'd1 : 16'd0);

      // Reset in the middle of a read discards it; memory is retained.
      rd(10'h010, 1'b0, 1'b0);
      nop();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         nop();
         check("post_rst_valid_l2", {15'b0, rd_valid2}, 16'h0);
         check("post_rst_valid_l4", {15'b0, rd_valid4}, 16'h0);
      end
      read_check("mem_kept", 10'h010, 1'b0, 1'b0, 16'hA55A);

      // 300 writes land in the latency-4 wait window; only 100 in the latency-2 one.
      for (int i = 0; i < 100; i++) begin
         rd(10'h3F0, 1'b0, 1'b0);
         repeat (3) wr(10'h3F0, 16'($urandom), 1'b0, 1'b0);
      end
      repeat (6) nop();
      check("sat_err_l4", {8'h0, err4}, CNT_ON ? 16'd255 : 16'd0);
      check("sat_err_l2", {8'h0, err2}, CNT_ON ? 16'd100 : 16'd0);

      for (int i = 0; i < 2000; i++) begin
         k  = $urandom_range(0, 9);
         a  = 10'($urandom_range(0, 15));
         v  = 16'($urandom);
         ln = 2'($urandom);
         if (k == 0)     cycle(1'b1, 1'b1, 1'b1, ln[1], ln[0], a, v);
         else if (k < 5) wr(a, v, ln[1], ln[0]);
         else if (k < 9) rd(a, ln[1], ln[0]);
         else            nop();
      end

      repeat (8) nop();
      @(negedge clk); #2;
      check("drain_q_l2", 16'(q0.size()), 16'h0);
      check("drain_q_l4", 16'(q1.size()), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
